// File: rtl/rtc_sweep_sched_if.sv
// RTC register bus between the sweep scheduler (master) and the RTC interface (slave).
// One request at a time; the slave answers with a single-cycle ack.
interface rtc_sweep_sched_if;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );
endinterface

// File: rtl/rtc_sweep_sched.sv
// Per-frame sweep of nine RTC time/date/chronometer registers into shadows, committed
// to the display outputs in one cycle; config writes are slotted in between reads.
module rtc_sweep_sched #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               frame_tick,
  input  logic               wr_req,
  input  logic [7:0]         wr_addr,
  input  logic [7:0]         wr_data,
  output logic               wr_ack,
  rtc_sweep_sched_if.master  bus,
  output logic [7:0]         data_out_hour_sec,
  output logic [7:0]         data_out_hour_min,
  output logic [7:0]         data_out_hour_h,
  output logic [7:0]         data_out_date_d,
  output logic [7:0]         data_out_date_m,
  output logic [7:0]         data_out_date_y,
  output logic [7:0]         data_out_cron_sec,
  output logic [7:0]         data_out_cron_min,
  output logic [7:0]         data_out_cron_h,
  output logic               busy,
  output logic               sweep_done,
  output logic               err
);

  localparam logic [7:0] ADDR_HOUR_SEC = 8'h21;
  localparam logic [7:0] ADDR_HOUR_MIN = 8'h22;
  localparam logic [7:0] ADDR_HOUR_H   = 8'h23;
  localparam logic [7:0] ADDR_DATE_D   = 8'h24;
  localparam logic [7:0] ADDR_DATE_M   = 8'h25;
  localparam logic [7:0] ADDR_DATE_Y   = 8'h26;
  localparam logic [7:0] ADDR_CRON_SEC = 8'h41;
  localparam logic [7:0] ADDR_CRON_MIN = 8'h42;
  localparam logic [7:0] ADDR_CRON_H   = 8'h43;

  localparam logic [3:0] LastIdx  = 4'd8;
  // Last wait count at which an ack is still accepted; bus_req is held TIMEOUT cycles.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StNext,
    StCommit,
    StWrReq,
    StWrDone
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] wait_q, wait_d;
  logic       pend_q, pend_d;
  logic       resume_q, resume_d;
  logic       timeout;
  logic       advance;

  logic       bus_req_q;
  logic       bus_we_q;
  logic [7:0] bus_addr_q;
  logic [7:0] bus_wdata_q;
  logic       sweep_done_q;
  logic       err_q;
  logic [7:0] shadow_q [9];
  logic [7:0] data_q   [9];

  function automatic logic [7:0] sweep_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    sweep_addr = ADDR_HOUR_SEC;
      4'd1:    sweep_addr = ADDR_HOUR_MIN;
      4'd2:    sweep_addr = ADDR_HOUR_H;
      4'd3:    sweep_addr = ADDR_DATE_D;
      4'd4:    sweep_addr = ADDR_DATE_M;
      4'd5:    sweep_addr = ADDR_DATE_Y;
      4'd6:    sweep_addr = ADDR_CRON_SEC;
      4'd7:    sweep_addr = ADDR_CRON_MIN;
      default: sweep_addr = ADDR_CRON_H;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    pend_d   = pend_q;
    resume_d = resume_q;
    timeout  = 1'b0;
    advance  = 1'b0;

    // A tick that cannot start a sweep right now is remembered once.
    if (frame_tick && ((state_q != StIdle) || wr_req)) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (wr_req) begin
          state_d  = StWrReq;
          wait_d   = 8'd0;
          resume_d = 1'b0;
        end else if (frame_tick || pend_q) begin
          pend_d  = 1'b0;
          idx_d   = 4'd0;
          wait_d  = 8'd0;
          state_d = StRdReq;
        end
      end
      StRdReq: begin
        if (bus.ack) begin
          state_d = StNext;
        end else if (wait_q == WaitLast) begin
          timeout = 1'b1;
          state_d = StIdle;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StNext: begin
        if (wr_req) begin
          state_d  = StWrReq;
          wait_d   = 8'd0;
          resume_d = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      StCommit: begin
        state_d = StIdle;
      end
      StWrReq: begin
        if (bus.ack) begin
          state_d = StWrDone;
        end else if (wait_q == WaitLast) begin
          timeout = 1'b1;
          state_d = StWrDone;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWrDone: begin
        if (resume_q) begin
          advance = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Step the sweep: either move to the next register or commit after the ninth.
    if (advance) begin
      resume_d = 1'b0;
      if (idx_q == LastIdx) begin
        state_d = StCommit;
      end else begin
        idx_d   = idx_q + 4'd1;
        wait_d  = 8'd0;
        state_d = StRdReq;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      idx_q        <= 4'd0;
      wait_q       <= 8'd0;
      pend_q       <= 1'b0;
      resume_q     <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 8'h00;
      bus_wdata_q  <= 8'h00;
      sweep_done_q <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        shadow_q[i] <= 8'h00;
        data_q[i]   <= 8'h00;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      pend_q   <= pend_d;
      resume_q <= resume_d;

      // Bus fields come from the next state so they are clean registers, zero when idle.
      bus_req_q   <= (state_d == StRdReq) || (state_d == StWrReq);
      bus_we_q    <= (state_d == StWrReq);
      bus_addr_q  <= (state_d == StRdReq) ? sweep_addr(idx_d) :
                     (state_d == StWrReq) ? wr_addr : 8'h00;
      bus_wdata_q <= (state_d == StWrReq) ? wr_data : 8'h00;

      if ((state_q == StRdReq) && bus.ack) begin
        shadow_q[idx_q] <= bus.rdata;
      end

      sweep_done_q <= (state_q == StCommit);
      if (state_q == StCommit) begin
        for (int i = 0; i < 9; i++) begin
          data_q[i] <= shadow_q[i];
        end
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.req   = bus_req_q;
  assign bus.we    = bus_we_q;
  assign bus.addr  = bus_addr_q;
  assign bus.wdata = bus_wdata_q;

  assign wr_ack     = (state_q == StWrDone);
  assign busy       = (state_q != StIdle);
  assign sweep_done = sweep_done_q;
  assign err        = err_q;

  assign data_out_hour_sec = data_q[0];
  assign data_out_hour_min = data_q[1];
  assign data_out_hour_h   = data_q[2];
  assign data_out_date_d   = data_q[3];
  assign data_out_date_m   = data_q[4];
  assign data_out_date_y   = data_q[5];
  assign data_out_cron_sec = data_q[6];
  assign data_out_cron_min = data_q[7];
  assign data_out_cron_h   = data_q[8];

endmodule

// File: tb/tb_rtc_sweep_sched.sv
// Directed scenarios for rtc_sweep_sched with a behavioural RTC slave; expected bus
// transactions, pulse cycles and committed bytes are derived from the timing rules.
module tb_rtc_sweep_sched;

  localparam int unsigned Tmo = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       wr_req = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ack;
  logic       busy;
  logic       sweep_done;
  logic       err;
  logic [7:0] outs [9];

  rtc_sweep_sched_if bus ();

  rtc_sweep_sched #(.TIMEOUT(Tmo)) dut (
    .CLK               (clk),
    .RESET_N           (rst_n),
    .frame_tick        (frame_tick),
    .wr_req            (wr_req),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_ack            (wr_ack),
    .bus               (bus),
    .data_out_hour_sec (outs[0]),
    .data_out_hour_min (outs[1]),
    .data_out_hour_h   (outs[2]),
    .data_out_date_d   (outs[3]),
    .data_out_date_m   (outs[4]),
    .data_out_date_y   (outs[5]),
    .data_out_cron_sec (outs[6]),
    .data_out_cron_min (outs[7]),
    .data_out_cron_h   (outs[8]),
    .busy              (busy),
    .sweep_done        (sweep_done),
    .err               (err)
  );

  always #5 clk = ~clk;

  logic [7:0] addr_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] rtc_val  [9];
  logic [7:0] exp_out  [9];
  int         hang_addr = -1;
  bit         hang_wr = 1'b0;

  function automatic logic [7:0] rd_val(input logic [7:0] a);
    rd_val = 8'hEE;
    for (int i = 0; i < 9; i++) if (addr_tab[i] == a) rd_val = rtc_val[i];
  endfunction

  // RTC slave: acks one cycle after seeing a request, unless told to hang.
  always @(posedge clk) begin
    if (bus.req && !bus.ack && !(bus.we ? hang_wr : (int'(bus.addr) == hang_addr))) begin
      bus.ack   <= 1'b1;
      bus.rdata <= bus.we ? 8'h00 : rd_val(bus.addr);
    end else begin
      bus.ack   <= 1'b0;
      bus.rdata <= 8'h00;
    end
  end

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pack(input logic we, input logic [7:0] a, input logic [7:0] d,
                                       input int st, input int len);
    pack = {15'd0, we, a, d, 16'(st), 16'(len)};
  endfunction

  logic [63:0] obs_q [$];
  logic [63:0] exp_q [$];
  int          done_q [$];
  int          ack_q [$];
  int          ticks [$];
  int          err_rise;
  int          out_chg;
  int          bus_bad;

  task automatic exp_sweep(input int c);
    for (int i = 0; i < 9; i++) exp_q.push_back(pack(1'b0, addr_tab[i], 8'h00, c + 1 + 3 * i, 2));
  endtask

  task automatic new_data();
    for (int i = 0; i < 9; i++) rtc_val[i] = outs[i] ^ 8'(1 + $urandom_range(254));
    exp_out = rtc_val;
  endtask

  // Watch cycles 0..n (cycle 0 = first sample); drives ticks/writes for the cycle sampled.
  task automatic observe(input int n, input int wr_at);
    logic       prev_req, prev_err, s_we;
    logic [7:0] s_addr, s_wd;
    logic [7:0] snap [9];
    int         st;
    obs_q.delete(); done_q.delete(); ack_q.delete();
    err_rise = -1; out_chg = -1; bus_bad = 0;
    snap = outs; prev_req = 1'b0; prev_err = err; st = 0;
    s_we = 1'b0; s_addr = 8'h00; s_wd = 8'h00;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (bus.req && !prev_req) begin
        st = k; s_we = bus.we; s_addr = bus.addr; s_wd = bus.wdata;
      end
      if (bus.req && (bus.we !== s_we || bus.addr !== s_addr || bus.wdata !== s_wd)) bus_bad++;
      if (!bus.req && prev_req) obs_q.push_back(pack(s_we, s_addr, s_wd, st, k - st));
      if (!bus.req && (bus.we !== 1'b0 || bus.addr !== 8'h00 || bus.wdata !== 8'h00)) bus_bad++;
      if (sweep_done) done_q.push_back(k);
      if (wr_ack) ack_q.push_back(k);
      if (err && !prev_err && err_rise < 0) err_rise = k;
      for (int i = 0; i < 9; i++) if (out_chg < 0 && outs[i] !== snap[i]) out_chg = k;
      prev_req = bus.req;
      prev_err = err;
      frame_tick = 1'b0;
      foreach (ticks[j]) if (ticks[j] == k) frame_tick = 1'b1;
      if (wr_ack) wr_req = 1'b0;
      else if (k == wr_at) wr_req = 1'b1;
    end
    frame_tick = 1'b0;
  endtask

  task automatic check_window(input string sc, input int d0, input int d1, input int wack,
                              input int erise, input logic err_end);
    int n;
    chk({sc, " req_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s req%0d", sc, i), obs_q[i], exp_q[i]);
    chk({sc, " done_count"}, done_q.size(), int'(d0 >= 0) + int'(d1 >= 0));
    if (d0 >= 0 && done_q.size() > 0) chk({sc, " done0_cycle"}, done_q[0], d0);
    if (d1 >= 0 && done_q.size() > 1) chk({sc, " done1_cycle"}, done_q[1], d1);
    chk({sc, " wr_ack_count"}, ack_q.size(), int'(wack >= 0));
    if (wack >= 0 && ack_q.size() > 0) chk({sc, " wr_ack_cycle"}, ack_q[0], wack);
    chk({sc, " err_rise"}, err_rise, erise);
    chk({sc, " err_end"}, err, err_end);
    chk({sc, " out_change_cycle"}, out_chg, d0);
    chk({sc, " bus_idle_stable"}, bus_bad, 0);
    chk({sc, " busy_end"}, busy, 1'b0);
    for (int i = 0; i < 9; i++) chk($sformatf("%s out%0d", sc, i), outs[i], exp_out[i]);
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string sc);
    chk({sc, " ctl_zero"}, {bus.req, bus.we, bus.addr, bus.wdata, wr_ack, busy, sweep_done, err},
        64'd0);
    for (int i = 0; i < 9; i++) chk($sformatf("%s out%0d_zero", sc, i), outs[i], 8'h00);
  endtask

  initial begin
    logic [7:0] wd;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Plain sweep: read i at 1+3i, commit visible at 29.
    for (int i = 0; i < 9; i++) rtc_val[i] = 8'h10 + 8'(i);
    exp_out = rtc_val;
    ticks = '{0};
    exp_sweep(0);
    observe(35, -1);
    check_window("sweep", 29, -1, -1, -1, 1'b0);

    // Write raised during the 4th read lands after its NEXT; sweep resumes at idx 4.
    new_data();
    wr_addr = 8'h22; wr_data = 8'h45;
    for (int i = 0; i < 4; i++) exp_q.push_back(pack(1'b0, addr_tab[i], 8'h00, 1 + 3 * i, 2));
    exp_q.push_back(pack(1'b1, 8'h22, 8'h45, 13, 2));
    for (int i = 4; i < 9; i++) exp_q.push_back(pack(1'b0, addr_tab[i], 8'h00, 4 + 3 * i, 2));
    observe(40, 10);
    check_window("wr_mid", 32, -1, 15, -1, 1'b0);

    // Extra ticks during a sweep collapse into one more sweep right after the commit.
    new_data();
    ticks = '{0, 5, 12, 20};
    exp_sweep(0);
    exp_sweep(29);
    observe(65, -1);
    check_window("pend", 29, 58, -1, -1, 1'b0);

    // Read timeout on date_y: bus_req high Tmo cycles, no commit, err set.
    exp_out = outs;
    for (int i = 0; i < 9; i++) rtc_val[i] = outs[i] ^ 8'(1 + $urandom_range(254));
    hang_addr = 8'h26;
    ticks = '{0};
    for (int i = 0; i < 5; i++) exp_q.push_back(pack(1'b0, addr_tab[i], 8'h00, 1 + 3 * i, 2));
    exp_q.push_back(pack(1'b0, 8'h26, 8'h00, 16, Tmo));
    observe(30, -1);
    check_window("rd_tmo", -1, -1, -1, 16 + Tmo, 1'b1);
    hang_addr = -1;
    exp_out = rtc_val;
    exp_sweep(0);
    observe(35, -1);
    check_window("rd_tmo_recover", 29, -1, -1, -1, 1'b0);

    // Reset while a read request is on the bus.
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid req_high", bus.req, 1'b1);
    chk("rst_mid addr", bus.addr, 8'h23);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    rst_n = 1'b1;
    new_data();
    exp_sweep(0);
    observe(35, -1);
    check_window("after_rst", 29, -1, -1, -1, 1'b0);

    // Write never acked: wr_ack still pulses, err set, pended tick sweeps afterwards.
    new_data();
    hang_wr = 1'b1;
    wd = 8'($urandom);
    wr_addr = 8'h41; wr_data = wd;
    ticks = '{3};
    exp_q.push_back(pack(1'b1, 8'h41, wd, 1, Tmo));
    exp_sweep(Tmo + 2);
    observe(45, 0);
    check_window("wr_tmo", Tmo + 31, -1, Tmo + 1, Tmo + 1, 1'b0);
    hang_wr = 1'b0;

    // Write and tick together in IDLE: write first, tick pends.
    new_data();
    wd = 8'($urandom);
    wr_addr = 8'h25; wr_data = wd;
    ticks = '{0};
    exp_q.push_back(pack(1'b1, 8'h25, wd, 1, 2));
    exp_sweep(4);
    observe(40, 0);
    check_window("wr_tick", 33, -1, 3, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
